// File: rtl/branch_compare_unit_pkg.sv
// Shared types and defaults for the branch compare unit.
//   brcmp_state_t        : FSM encoding (IDLE / CMP / DONE)
//   BRCMP_XLEN_DEFAULT   : default operand width
//   BRCMP_CHUNK_DEFAULT  : default bits compared per cycle
package branch_compare_unit_pkg;

  localparam int unsigned BRCMP_XLEN_DEFAULT  = 32;
  localparam int unsigned BRCMP_CHUNK_DEFAULT = 8;

  typedef enum logic [1:0] {
    BRCMP_IDLE = 2'd0,
    BRCMP_CMP  = 2'd1,
    BRCMP_DONE = 2'd2
  } brcmp_state_t;

endpackage

// File: rtl/branch_compare_unit_if.sv
// Request/response bundle between the hazard unit and the branch compare unit.
//   start_i / rs1_data_i / rs2_data_i / flush_i : requester -> comparator
//   ready_o / valid_o / BrEq_o / BrLT_o / BrLTU_o : comparator -> requester
// master: hazard/decode side, slave: branch_compare_unit.
interface branch_compare_unit_if
  import branch_compare_unit_pkg::*;
#(
  parameter int unsigned XLEN = BRCMP_XLEN_DEFAULT
);
  logic            start_i;
  logic [XLEN-1:0] rs1_data_i;
  logic [XLEN-1:0] rs2_data_i;
  logic            flush_i;
  logic            ready_o;
  logic            valid_o;
  logic            BrEq_o;
  logic            BrLT_o;
  logic            BrLTU_o;

  modport master (
    output start_i, rs1_data_i, rs2_data_i, flush_i,
    input  ready_o, valid_o, BrEq_o, BrLT_o, BrLTU_o
  );

  modport slave (
    input  start_i, rs1_data_i, rs2_data_i, flush_i,
    output ready_o, valid_o, BrEq_o, BrLT_o, BrLTU_o
  );
endinterface

// File: rtl/branch_compare_unit_chunk_cmp.sv
// Combinational W-bit slice comparator.
//   a, b   : operand slices
//   is_msb : slice holds the operand sign bit (enables signed resolution)
//   eq     : a == b
//   ltu    : a < b unsigned
//   lt     : a < b signed when is_msb, else equals ltu (higher slices equal)
module brcmp_chunk_cmp #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         is_msb,
  output logic         eq,
  output logic         ltu,
  output logic         lt
);

  logic w_sign_diff;

  assign eq          = (a == b);
  assign ltu         = (a < b);
  assign w_sign_diff = is_msb && (a[W-1] != b[W-1]);
  // Differing signs: the negative operand (sign bit set) is the smaller one.
  assign lt          = w_sign_diff ? a[W-1] : ltu;

endmodule

// File: rtl/branch_compare_unit.sv
// Iterative BrEq/BrLT/BrLTU generator for the decode stage.
// Compares CHUNK bits per cycle, MSB chunk first, stopping at the first
// differing chunk; latency is variable and absorbed by a start/ready/valid
// handshake.
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset
//   io_bus : branch_compare_unit_if.slave (start/operands/flush in,
//            ready/valid/flags out; all outputs registered)
// Build option: BRCMP_SINGLE_CYCLE_EN compares the full words in one CMP
// cycle and drops the chunk index.
module branch_compare_unit
  import branch_compare_unit_pkg::*;
#(
  parameter int unsigned XLEN  = BRCMP_XLEN_DEFAULT,
  parameter int unsigned CHUNK = BRCMP_CHUNK_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_compare_unit_if.slave  io_bus
);

  brcmp_state_t    r_state, w_state_nxt;
  logic [XLEN-1:0] r_op_a, w_op_a_nxt;
  logic [XLEN-1:0] r_op_b, w_op_b_nxt;
  logic            r_ready, r_valid;
  logic            r_eq, w_eq_nxt;
  logic            r_lt, w_lt_nxt;
  logic            r_ltu, w_ltu_nxt;

  logic            w_cmp_eq, w_cmp_lt, w_cmp_ltu;
  logic            w_last;

`ifdef BRCMP_SINGLE_CYCLE_EN
  // Whole-word compare: every CMP cycle is final.
  brcmp_chunk_cmp #(.W(XLEN)) u_cmp (
    .a      (r_op_a),
    .b      (r_op_b),
    .is_msb (1'b1),
    .eq     (w_cmp_eq),
    .ltu    (w_cmp_ltu),
    .lt     (w_cmp_lt)
  );

  assign w_last = 1'b1;
`else
  localparam int unsigned NCHUNK = XLEN / CHUNK;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  logic [IDXW-1:0]  r_idx, w_idx_nxt;
  logic [CHUNK-1:0] w_a_chunk, w_b_chunk;
  logic             w_is_msb;

  // Select chunk r_idx of each latched operand.
  assign w_a_chunk = CHUNK'(r_op_a >> (32'(r_idx) * CHUNK));
  assign w_b_chunk = CHUNK'(r_op_b >> (32'(r_idx) * CHUNK));
  assign w_is_msb  = (r_idx == IDXW'(NCHUNK - 1));
  assign w_last    = (r_idx == '0);

  brcmp_chunk_cmp #(.W(CHUNK)) u_cmp (
    .a      (w_a_chunk),
    .b      (w_b_chunk),
    .is_msb (w_is_msb),
    .eq     (w_cmp_eq),
    .ltu    (w_cmp_ltu),
    .lt     (w_cmp_lt)
  );
`endif

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt = r_state;
    w_op_a_nxt  = r_op_a;
    w_op_b_nxt  = r_op_b;
    w_eq_nxt    = r_eq;
    w_lt_nxt    = r_lt;
    w_ltu_nxt   = r_ltu;
`ifndef BRCMP_SINGLE_CYCLE_EN
    w_idx_nxt   = r_idx;
`endif

    case (r_state)
      BRCMP_IDLE: begin
        if (io_bus.start_i && !io_bus.flush_i) begin
          w_op_a_nxt  = io_bus.rs1_data_i;
          w_op_b_nxt  = io_bus.rs2_data_i;
`ifndef BRCMP_SINGLE_CYCLE_EN
          w_idx_nxt   = IDXW'(NCHUNK - 1);
`endif
          w_state_nxt = BRCMP_CMP;
        end
      end
      BRCMP_CMP: begin
        // A differing chunk decides everything; equal LSB chunk means A == B,
        // in which case the comparator already reports eq=1, lt=0, ltu=0.
        if (!w_cmp_eq || w_last) begin
          w_eq_nxt    = w_cmp_eq;
          w_lt_nxt    = w_cmp_lt;
          w_ltu_nxt   = w_cmp_ltu;
          w_state_nxt = BRCMP_DONE;
        end
`ifndef BRCMP_SINGLE_CYCLE_EN
        else begin
          w_idx_nxt = r_idx - IDXW'(1);
        end
`endif
      end
      BRCMP_DONE: w_state_nxt = BRCMP_IDLE;
      default:    w_state_nxt = BRCMP_IDLE;
    endcase

    // Abort: drop to IDLE, keep the last published flags.
    if (io_bus.flush_i) begin
      w_state_nxt = BRCMP_IDLE;
      w_eq_nxt    = r_eq;
      w_lt_nxt    = r_lt;
      w_ltu_nxt   = r_ltu;
    end
  end

  // State, operand, flag and handshake registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= BRCMP_IDLE;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_eq    <= 1'b0;
      r_lt    <= 1'b0;
      r_ltu   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_op_a  <= w_op_a_nxt;
      r_op_b  <= w_op_b_nxt;
      r_ready <= (w_state_nxt == BRCMP_IDLE);
      r_valid <= (w_state_nxt == BRCMP_DONE);
      r_eq    <= w_eq_nxt;
      r_lt    <= w_lt_nxt;
      r_ltu   <= w_ltu_nxt;
    end
  end

`ifndef BRCMP_SINGLE_CYCLE_EN
  // Chunk index register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
    end else begin
      r_idx <= w_idx_nxt;
    end
  end
`endif

  assign io_bus.ready_o = r_ready;
  assign io_bus.valid_o = r_valid;
  assign io_bus.BrEq_o  = r_eq;
  assign io_bus.BrLT_o  = r_lt;
  assign io_bus.BrLTU_o = r_ltu;

endmodule

// File: doc/branch_compare_unit.md
# branch_compare_unit

Iterative operand comparator for the decode stage. It produces the BrEq/BrLT/BrLTU flags consumed by branch_determination. rs1/rs2 values are compared CHUNK bits per cycle, most significant chunk first, and the compare stops early at the first differing chunk. This reduces the comparator area and critical path, at the cost of a variable latency that the hazard unit absorbs through a start/ready/valid handshake.

## Interface
- XLEN, 32, operand width.
- CHUNK, 8, bits compared per cycle. Must divide XLEN. NCHUNK = XLEN/CHUNK.
- clk  input  1  clock, rising-edge active.
- rst  input  1  reset, asynchronous, active-high.
- start_i  input  1  request a compare. Accepted only when start_i && ready_o.
- rs1_data_i  input  XLEN  operand A, sampled at accept.
- rs2_data_i  input  XLEN  operand B, sampled at accept.
- flush_i  input  1  abort any compare in flight (from the hazard unit).
- ready_o  output  1  high in IDLE only.
- valid_o  output  1  one-cycle pulse: flags are valid.
- BrEq_o  output  1  A == B.
- BrLT_o  output  1  A < B, signed.
- BrLTU_o  output  1  A < B, unsigned.

## Operation
- States: IDLE, CMP, DONE.
- IDLE:
  - ready_o = 1.
  - On accept: latch both operands, set chunk index idx = NCHUNK-1, go to CMP.
- CMP: compare chunk idx of A and B.
  - Chunks differ: set BrEq=0 and BrLTU = (A chunk < B chunk) unsigned. Go to DONE.
  - Signed result in the MSB chunk: if the sign bits differ, BrLT = A[XLEN-1]. Otherwise BrLT = BrLTU.
  - Signed result in lower chunks: BrLT = BrLTU, because the higher chunks are equal and so the signs are equal.
  - Chunks equal and idx == 0: set BrEq=1, BrLT=0, BrLTU=0. Go to DONE.
  - Chunks equal and idx > 0: decrement idx, stay in CMP.
- DONE: valid_o = 1 for this cycle only, then go to IDLE.
- Flag outputs are registered and hold their values until the next DONE. They are updated on the CMP→DONE transition.
- flush_i from any state:
  - Next state is IDLE and no valid_o pulse is produced.
  - Flags keep their previous values.
- flush_i and start_i together in IDLE: flush wins and the request is not accepted.
- start_i while not ready: ignored. Operands are not re-latched.
- Reset (asynchronous, can occur mid-operation):
  - State goes to IDLE, idx = 0, latched operands = 0.
  - ready_o=1, valid_o=0, BrEq_o=0, BrLT_o=0, BrLTU_o=0.

## Timing
- Accept happens at rising edge t. CMP examines one chunk per cycle starting in cycle t+1.
- If k chunks are examined (1 ≤ k ≤ NCHUNK), DONE and valid_o occur in cycle t+k+1.
- Best case is 2 cycles (MSB chunk differs). Worst case is NCHUNK+1 = 5 cycles (equal operands, or only the LSB chunk differs).
- ready_o is low from cycle t+1 through DONE. It goes high in the cycle after DONE.
- Back-to-back: the next accept can occur in the cycle after DONE.
- No combinational path from any input to any output.

## Configuration
- BRCMP_SINGLE_CYCLE_EN defined:
  - CMP compares the full words in one cycle: equality, unsigned less-than, and signed less-than.
  - valid_o occurs in cycle t+2 for every operand pair.
  - idx logic is removed.
- BRCMP_SINGLE_CYCLE_EN undefined: iterative behaviour as described above.
- Handshake and reset behaviour are identical in both builds.

## Structure
- Package defines gets:
  - typedef enum logic [1:0] brcmp_state_t {BRCMP_IDLE, BRCMP_CMP, BRCMP_DONE}.
  - localparam BRCMP_CHUNK_DEFAULT = 8.
- Sub-module brcmp_chunk_cmp: combinational CHUNK-wide comparator.
  - Inputs: a, b, is_msb.
  - Outputs: eq, ltu, lt.
  - Instantiated once and fed by idx-selected slices.
- Top-level holds the FSM, idx counter, operand and flag registers.

## Test plan
- rs1=rs2=0x12345678 → valid_o at t+5, Eq=1, LT=0, LTU=0. ready_o low t+1..t+5, high at t+6.
- rs1=0x80000000, rs2=0x00000001 → valid_o at t+2, Eq=0, LT=1, LTU=0.
- rs1=0x00001234, rs2=0x00001300 → valid_o at t+4, Eq=0, LT=1, LTU=1.
- rs1=rs2=5, flush_i pulsed at t+2 → no valid_o, ready_o=1 at t+3, flags unchanged. A new start at t+3 is accepted.
- Other control cases:
  - start_i held high with new operands during CMP → ignored, result reflects the first operands.
  - rst asserted at t+2 → all outputs return to reset values immediately.
  - start_i+flush_i together in IDLE → no accept.
- BRCMP_SINGLE_CYCLE_EN defined:
  - rs1=0xFFFFFFFF, rs2=0x00000000 → valid_o at t+2, LT=1, LTU=0, Eq=0.
  - Equal operands → valid_o at t+2, Eq=1.
